alu_operand_stage: RTL and testbench

- Parametrised successor to the single-format ALU operand-B mux.
- Decodes all five RV immediate formats (I/S/B/U/J) to XLEN and forwards rs1/rs2 from the EX/MEM stages.
- Selects both ALU operands A and B.
- Registers the result in a one-deep valid/ready pipeline stage with flush, sitting between ID and EX.

---
 rtl/alu_operand_stage.sv | 135 +++++++++++++
 tb/tb_alu_operand_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: RV immediate decode, EX/MEM forwarding, operand A/B select,
// registered in a one-deep valid/ready pipeline slot with flush.
module alu_operand_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [31:0]     inst_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rs1_value_in,
    input  logic [XLEN-1:0] rs2_value_in,
    input  logic [2:0]      imm_fmt_in,
    input  logic [1:0]      a_sel_in,
    input  logic [1:0]      b_sel_in,
    input  logic [1:0]      fwd_a_in,
    input  logic [1:0]      fwd_b_in,
    input  logic [XLEN-1:0] ex_fwd_value_in,
    input  logic [XLEN-1:0] mem_fwd_value_in,
    input  logic            flush_in,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [XLEN-1:0] op_a_out,
    output logic [XLEN-1:0] op_b_out,
    output logic [XLEN-1:0] rs2_store_out,
    output logic [XLEN-1:0] trace_imm
);

    logic signed [31:0] imm32;
    logic [XLEN-1:0]    imm_x;
    logic [XLEN-1:0]    rs1f, rs2f;
    logic [XLEN-1:0]    op_a_sel, op_b_sel;
    logic               accept, handoff;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] imm_q, imm_d;

    always_comb begin
        imm32 = '0;
        case (imm_fmt_in)
            3'd0: imm32 = {{20{inst_in[31]}}, inst_in[31:20]};
            3'd1: imm32 = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
            3'd2: imm32 = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25],
                           inst_in[11:8], 1'b0};
            3'd3: imm32 = {inst_in[31:12], 12'h000};
            3'd4: imm32 = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20],
                           inst_in[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed source, so the size cast replicates inst[31] up to the full XLEN.
    assign imm_x = XLEN'(imm32);

    always_comb begin
        rs1f = rs1_value_in;
        rs2f = rs2_value_in;
        case (fwd_a_in)
            2'd1:    rs1f = ex_fwd_value_in;
            2'd2:    rs1f = mem_fwd_value_in;
            default: rs1f = rs1_value_in;
        endcase
        case (fwd_b_in)
            2'd1:    rs2f = ex_fwd_value_in;
            2'd2:    rs2f = mem_fwd_value_in;
            default: rs2f = rs2_value_in;
        endcase
    end

    always_comb begin
        op_a_sel = '0;
        op_b_sel = '0;
        case (a_sel_in)
            2'd0:    op_a_sel = rs1f;
            2'd1:    op_a_sel = pc_in;
            default: op_a_sel = '0;
        endcase
        case (b_sel_in)
            2'd0:    op_b_sel = rs2f;
            2'd1:    op_b_sel = imm_x;
            2'd2:    op_b_sel = XLEN'(3'd4);
            default: op_b_sel = '0;
        endcase
    end

    assign ready_out = !valid_q || ready_in;
    assign accept    = valid_in && ready_out;
    assign handoff   = valid_q && ready_in;

    always_comb begin
        valid_d = valid_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        if (flush_in) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            op_a_d  = op_a_sel;
            op_b_d  = op_b_sel;
            rs2_d   = rs2f;
            imm_d   = imm_x;
        end else if (handoff) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
        end else begin
            valid_q <= valid_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
        end
    end

    assign valid_out     = valid_q;
    assign op_a_out      = op_a_q;
    assign op_b_out      = op_b_q;
    assign rs2_store_out = rs2_q;
    assign trace_imm     = imm_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: driver pushes model results, a negedge monitor
// pops and compares on every handoff; directed cases cover immediates, forwarding, stall, flush.
module tb_alu_operand_stage;

    localparam int unsigned XLEN = 32;

    typedef struct {
        logic            valid;
        logic            ready;
        logic            flush;
        logic [31:0]     inst;
        logic [XLEN-1:0] pc, rs1, rs2, ex, mem;
        logic [2:0]      fmt;
        logic [1:0]      a_sel, b_sel, fwd_a, fwd_b;
    } stim_t;

    typedef struct {
        logic [XLEN-1:0] op_a, op_b, rs2, imm;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_in, ready_out, flush, valid_out, ready_in;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc, rs1, rs2, ex, mem;
    logic [2:0]      fmt;
    logic [1:0]      a_sel, b_sel, fwd_a, fwd_b;
    logic [XLEN-1:0] op_a, op_b, rs2_store, trace_imm;

    logic [63:0] pc64, rs1_64, rs2_64, ex64, mem64;
    logic [63:0] op_a64, op_b64, rs2_store64, trace_imm64;
    logic        ready_out64, valid_out64;

    assign pc64   = {32'h0, pc};
    assign rs1_64 = {32'h0, rs1};
    assign rs2_64 = {32'h0, rs2};
    assign ex64   = {32'h0, ex};
    assign mem64  = {32'h0, mem};

    always #5 clk = ~clk;

    alu_operand_stage #(.XLEN(XLEN)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(ready_out),
        .inst_in(inst), .pc_in(pc), .rs1_value_in(rs1), .rs2_value_in(rs2),
        .imm_fmt_in(fmt), .a_sel_in(a_sel), .b_sel_in(b_sel), .fwd_a_in(fwd_a),
        .fwd_b_in(fwd_b), .ex_fwd_value_in(ex), .mem_fwd_value_in(mem), .flush_in(flush),
        .valid_out(valid_out), .ready_in(ready_in), .op_a_out(op_a), .op_b_out(op_b),
        .rs2_store_out(rs2_store), .trace_imm(trace_imm)
    );

    alu_operand_stage #(.XLEN(64)) dut64 (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(ready_out64),
        .inst_in(inst), .pc_in(pc64), .rs1_value_in(rs1_64), .rs2_value_in(rs2_64),
        .imm_fmt_in(fmt), .a_sel_in(a_sel), .b_sel_in(b_sel), .fwd_a_in(fwd_a),
        .fwd_b_in(fwd_b), .ex_fwd_value_in(ex64), .mem_fwd_value_in(mem64), .flush_in(flush),
        .valid_out(valid_out64), .ready_in(ready_in), .op_a_out(op_a64), .op_b_out(op_b64),
        .rs2_store_out(rs2_store64), .trace_imm(trace_imm64)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    bit   occ = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Immediates built arithmetically from the sign-shifted word rather than bit concatenation.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] f);
        longint s;
        s = longint'($signed(i));
        case (f)
            3'd0: return 64'(s >>> 20);
            3'd1: return 64'(((s >>> 20) & ~longint'(32'h1F)) | longint'(i[11:7]));
            3'd2: return 64'(((s >>> 19) & ~longint'(32'hFFF)) | (longint'(i[7]) << 11)
                             | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1));
            3'd3: return 64'(s & ~longint'(32'hFFF));
            3'd4: return 64'(((s >>> 11) & ~longint'(32'hFFFFF)) | (longint'(i[19:12]) << 12)
                             | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1));
            default: return 64'h0;
        endcase
    endfunction

    function automatic exp_t ref_model(input stim_t s);
        exp_t e;
        logic [XLEN-1:0] r1, r2, imm;
        r1  = (s.fwd_a == 2'd1) ? s.ex : (s.fwd_a == 2'd2) ? s.mem : s.rs1;
        r2  = (s.fwd_b == 2'd1) ? s.ex : (s.fwd_b == 2'd2) ? s.mem : s.rs2;
        imm = XLEN'(ref_imm(s.inst, s.fmt));
        e.op_a = (s.a_sel == 2'd0) ? r1 : (s.a_sel == 2'd1) ? s.pc : '0;
        e.op_b = (s.b_sel == 2'd0) ? r2 : (s.b_sel == 2'd1) ? imm :
                 (s.b_sel == 2'd2) ? XLEN'(4) : '0;
        e.rs2  = r2;
        e.imm  = imm;
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.valid = 1'b0; s.ready = 1'b1; s.flush = 1'b0; s.inst = '0;
        s.pc = '0; s.rs1 = '0; s.rs2 = '0; s.ex = '0; s.mem = '0;
        s.fmt = '0; s.a_sel = '0; s.b_sel = '0; s.fwd_a = '0; s.fwd_b = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.valid = ($urandom_range(3) != 0);
        s.ready = ($urandom_range(3) != 0);
        s.flush = ($urandom_range(15) == 0);
        s.inst  = $urandom();
        s.pc    = $urandom();
        s.rs1   = $urandom();
        s.rs2   = $urandom();
        s.ex    = $urandom();
        s.mem   = $urandom();
        s.fmt   = 3'($urandom_range(7));
        s.a_sel = 2'($urandom_range(3));
        s.b_sel = 2'($urandom_range(3));
        s.fwd_a = 2'($urandom_range(3));
        s.fwd_b = 2'($urandom_range(3));
        return s;
    endfunction

    // Drive one cycle, then advance the handshake model across the rising edge.
    task automatic issue(input stim_t s);
        bit hand, acc;
        valid_in = s.valid; ready_in = s.ready; flush = s.flush; inst = s.inst;
        pc = s.pc; rs1 = s.rs1; rs2 = s.rs2; ex = s.ex; mem = s.mem; fmt = s.fmt;
        a_sel = s.a_sel; b_sel = s.b_sel; fwd_a = s.fwd_a; fwd_b = s.fwd_b;
        @(posedge clk);
        hand = occ && s.ready;
        acc  = s.valid && (!occ || s.ready);
        if (s.flush) begin
            sb.delete();
            occ = 1'b0;
        end else if (acc) begin
            sb.push_back(ref_model(s));
            occ = 1'b1;
        end else if (hand) begin
            occ = 1'b0;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("valid_out", 64'(valid_out), 64'(occ));
            check("ready_out", 64'(ready_out), 64'(!occ || ready_in));
            if (valid_out) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_empty: got valid_out=1 required no pending item");
                end else begin
                    check("op_a", 64'(op_a), 64'(sb[0].op_a));
                    check("op_b", 64'(op_b), 64'(sb[0].op_b));
                    check("rs2_store", 64'(rs2_store), 64'(sb[0].rs2));
                    check("trace_imm", 64'(trace_imm), 64'(sb[0].imm));
                    if (ready_in) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        stim_t s;
        exp_t  e;
        rst_n = 1'b0;
        issue(idle());
        check("rst_valid", 64'(valid_out), 64'h0);
        check("rst_ready", 64'(ready_out), 64'h1);
        check("rst_op_b", 64'(op_b), 64'h0);
        rst_n = 1'b1;

        s = idle(); s.valid = 1'b1; s.inst = 32'hFFF00093; s.fmt = 3'd0;
        s.b_sel = 2'd1; s.rs1 = 32'h10;
        issue(s);
        check("i_op_a", 64'(op_a), 64'h10);
        check("i_op_b", 64'(op_b), 64'hFFFFFFFF);
        check("i_trace", 64'(trace_imm), 64'hFFFFFFFF);
        check("i_valid", 64'(valid_out), 64'h1);

        s = idle(); s.valid = 1'b1; s.inst = 32'hFE112E23; s.fmt = 3'd1;
        s.b_sel = 2'd1; s.rs2 = 32'hCAFEBABE;
        issue(s);
        check("s_op_b", 64'(op_b), 64'hFFFFFFFC);
        check("s_rs2_store", 64'(rs2_store), 64'hCAFEBABE);
        check("s64_op_b", op_b64, 64'hFFFFFFFFFFFFFFFC);
        check("s64_trace", trace_imm64, 64'hFFFFFFFFFFFFFFFC);

        s = idle(); s.valid = 1'b1; s.inst = 32'h123452B7; s.fmt = 3'd3;
        s.a_sel = 2'd2; s.b_sel = 2'd1; s.rs1 = 32'h55;
        issue(s);
        check("u_op_a", 64'(op_a), 64'h0);
        check("u_op_b", 64'(op_b), 64'h12345000);

        s = idle(); s.valid = 1'b1; s.rs1 = 32'd1; s.ex = 32'd2; s.mem = 32'd3;
        s.rs2 = 32'd7; s.fwd_a = 2'd1; s.fwd_b = 2'd2; s.b_sel = 2'd0;
        issue(s);
        check("fwd_op_a", 64'(op_a), 64'd2);
        check("fwd_op_b", 64'(op_b), 64'd3);
        check("fwd_rs2_store", 64'(rs2_store), 64'd3);
        s.fwd_a = 2'd3;
        issue(s);
        check("fwd3_op_a", 64'(op_a), 64'd1);
        issue(idle());

        s = rand_stim(); s.valid = 1'b1; s.ready = 1'b0; s.flush = 1'b0;
        issue(s);
        for (int k = 0; k < 5; k++) begin
            s = rand_stim(); s.valid = 1'b1; s.ready = 1'b0; s.flush = 1'b0;
            issue(s);
            check("stall_ready_out", 64'(ready_out), 64'h0);
        end
        s = rand_stim(); s.valid = 1'b1; s.ready = 1'b1; s.flush = 1'b0;
        e = ref_model(s);
        issue(s);
        check("b2b_valid", 64'(valid_out), 64'h1);
        check("b2b_op_a", 64'(op_a), 64'(e.op_a));
        issue(idle());

        s = rand_stim(); s.valid = 1'b1; s.ready = 1'b0; s.flush = 1'b0;
        issue(s);
        s = rand_stim(); s.valid = 1'b1; s.ready = 1'b0; s.flush = 1'b1;
        issue(s);
        check("flush_valid", 64'(valid_out), 64'h0);
        issue(idle());
        check("flush_dropped", 64'(valid_out), 64'h0);

        s = rand_stim(); s.valid = 1'b1; s.ready = 1'b0; s.flush = 1'b0;
        issue(s);
        issue(s);
        #2;
        rst_n = 1'b0;
        sb.delete();
        occ = 1'b0;
        #1;
        check("mid_rst_valid", 64'(valid_out), 64'h0);
        check("mid_rst_ready", 64'(ready_out), 64'h1);
        check("mid_rst_ops", 64'({op_a, op_b}), 64'h0);
        check("mid_rst_rest", 64'({rs2_store, trace_imm}), 64'h0);
        check("mid_rst_64", op_b64 | trace_imm64, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s = rand_stim(); s.valid = 1'b1; s.ready = 1'b1; s.flush = 1'b0;
        e = ref_model(s);
        issue(s);
        check("post_rst_valid", 64'(valid_out), 64'h1);
        check("post_rst_op_b", 64'(op_b), 64'(e.op_b));

        for (int k = 0; k < 400; k++) issue(rand_stim());

        for (int k = 0; k < 10 && sb.size() != 0; k++) issue(idle());
        issue(idle());
        check("drain_empty", 64'(sb.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
